vga_textmap_ctrl: RTL and testbench

Sequencer and arbiter for port A of the text-mode character map and colour map (80x30 cells, 8-bit char + 8-bit colour). It shares those ports between a bus requester (register-interface side) and an internal engine that performs whole-screen CLEAR and one-row SCROLL-UP. It sits between the register block and the `ch_map_*` / `col_map_*` ports of the text-mode top and runs entirely in the system clock domain.

---
 rtl/vga_textmap_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_vga_textmap_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_textmap_ctrl.sv
// Port-A sequencer/arbiter for the text-mode char and colour maps: whole-screen CLEAR,
// one-row SCROLL-UP and single-cycle bus accesses. Optional macro: VGA_TEXTMAP_SCROLL_EN.
module vga_textmap_ctrl #(
    parameter int COLS = 80,
    parameter int ROWS = 30,
    parameter int AW   = $clog2(COLS * ROWS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [1:0]    cmd_op_i,
    input  logic [7:0]    cmd_char_i,
    input  logic [7:0]    cmd_color_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          cmd_err_o,
    input  logic          bus_req_i,
    input  logic          bus_we_i,
    input  logic          bus_sel_i,
    input  logic [AW-1:0] bus_addr_i,
    input  logic [7:0]    bus_wdata_i,
    output logic          bus_gnt_o,
    output logic          bus_rvalid_o,
    output logic [7:0]    bus_rdata_o,
    output logic [AW-1:0] ch_map_addr_o,
    output logic [AW-1:0] col_map_addr_o,
    output logic          ch_map_wen_o,
    output logic          col_map_wen_o,
    output logic [7:0]    ch_map_data_o,
    output logic [7:0]    col_map_data_o,
    input  logic [7:0]    ch_map_data_i,
    input  logic [7:0]    col_map_data_i
);

    localparam int N = COLS * ROWS;
    localparam logic [AW-1:0] LAST_A = AW'(N - 1);
`ifdef VGA_TEXTMAP_SCROLL_EN
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);
    localparam logic [AW-1:0] SC_LAST_A = AW'(N - COLS - 1);
    localparam logic [AW-1:0] FILL_A    = AW'(N - COLS);
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        DONE  = 3'd2
`ifdef VGA_TEXTMAP_SCROLL_EN
        ,
        SC_RD   = 3'd3,
        SC_WR   = 3'd4,
        SC_FILL = 3'd5
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [7:0]    fill_ch_q, fill_ch_d;
    logic [7:0]    fill_col_q, fill_col_d;
    logic          bus_turn_q, bus_turn_d;
    logic          rvalid_q, rvalid_d;
    logic          rsel_q, rsel_d;
    logic [AW-1:0] ch_addr_q, ch_addr_d;
    logic [AW-1:0] col_addr_q, col_addr_d;
    logic          gnt;
    logic          accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fill_ch_q  <= '0;
            fill_col_q <= '0;
            bus_turn_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rsel_q     <= 1'b0;
            ch_addr_q  <= '0;
            col_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_ch_q  <= fill_ch_d;
            fill_col_q <= fill_col_d;
            bus_turn_q <= bus_turn_d;
            rvalid_q   <= rvalid_d;
            rsel_q     <= rsel_d;
            ch_addr_q  <= ch_addr_d;
            col_addr_q <= col_addr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        fill_ch_d      = fill_ch_q;
        fill_col_d     = fill_col_q;
        ch_addr_d      = ch_addr_q;
        col_addr_d     = col_addr_q;
        ch_map_wen_o   = 1'b0;
        col_map_wen_o  = 1'b0;
        ch_map_data_o  = '0;
        col_map_data_o = '0;
        cmd_err_o      = 1'b0;
        accept         = 1'b0;

        // The bus may take an engine issue slot only if it did not take the previous one.
        case (state_q)
            IDLE:    gnt = bus_req_i;
            CLR:     gnt = bus_req_i & ~bus_turn_q;
`ifdef VGA_TEXTMAP_SCROLL_EN
            SC_RD:   gnt = bus_req_i & ~bus_turn_q;
            SC_FILL: gnt = bus_req_i & ~bus_turn_q;
`endif
            default: gnt = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd_op_i)
                        2'b00: begin
                            state_d = CLR;
                            accept  = 1'b1;
                        end
`ifdef VGA_TEXTMAP_SCROLL_EN
                        2'b01: begin
                            state_d = SC_RD;
                            accept  = 1'b1;
                        end
`endif
                        default: cmd_err_o = 1'b1;
                    endcase
                end
                if (accept) begin
                    fill_ch_d  = cmd_char_i;
                    fill_col_d = cmd_color_i;
                    cnt_d      = '0;
                end
            end
            CLR: begin
                if (!gnt) begin
                    ch_map_wen_o   = 1'b1;
                    col_map_wen_o  = 1'b1;
                    ch_addr_d      = cnt_q;
                    col_addr_d     = cnt_q;
                    ch_map_data_o  = fill_ch_q;
                    col_map_data_o = fill_col_q;
                    if (cnt_q == LAST_A) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
`ifdef VGA_TEXTMAP_SCROLL_EN
            SC_RD: begin
                if (!gnt) begin
                    ch_addr_d  = cnt_q + COLS_A;
                    col_addr_d = cnt_q + COLS_A;
                    state_d    = SC_WR;
                end
            end
            // Read data from the SC_RD cycle arrives now and is written one row up.
            SC_WR: begin
                ch_map_wen_o   = 1'b1;
                col_map_wen_o  = 1'b1;
                ch_addr_d      = cnt_q;
                col_addr_d     = cnt_q;
                ch_map_data_o  = ch_map_data_i;
                col_map_data_o = col_map_data_i;
                if (cnt_q == SC_LAST_A) begin
                    cnt_d   = FILL_A;
                    state_d = SC_FILL;
                end else begin
                    cnt_d   = cnt_q + AW'(1);
                    state_d = SC_RD;
                end
            end
            SC_FILL: begin
                if (!gnt) begin
                    ch_map_wen_o   = 1'b1;
                    col_map_wen_o  = 1'b1;
                    ch_addr_d      = cnt_q;
                    col_addr_d     = cnt_q;
                    ch_map_data_o  = fill_ch_q;
                    col_map_data_o = fill_col_q;
                    if (cnt_q == LAST_A) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (gnt) begin
            if (bus_sel_i) begin
                col_addr_d     = bus_addr_i;
                col_map_wen_o  = bus_we_i;
                col_map_data_o = bus_wdata_i;
            end else begin
                ch_addr_d     = bus_addr_i;
                ch_map_wen_o  = bus_we_i;
                ch_map_data_o = bus_wdata_i;
            end
        end
        bus_turn_d = gnt;
        rvalid_d   = gnt & ~bus_we_i;
        rsel_d     = gnt ? bus_sel_i : rsel_q;
    end

    assign ch_map_addr_o  = ch_addr_d;
    assign col_map_addr_o = col_addr_d;
    assign bus_gnt_o      = gnt;
    assign cmd_ready_o    = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE) && (state_q != DONE);
    assign done_o         = (state_q == DONE);
    assign bus_rvalid_o   = rvalid_q;
    assign bus_rdata_o    = rvalid_q ? (rsel_q ? col_map_data_i : ch_map_data_i) : 8'h00;

endmodule

// File: tb/tb_vga_textmap_ctrl.sv
// Self-checking bench for vga_textmap_ctrl: the bench owns both maps and an operation-level model.
module tb_vga_textmap_ctrl;
    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int N    = COLS * ROWS;
    localparam int AW   = 12;
`ifdef VGA_TEXTMAP_SCROLL_EN
    localparam bit SCROLL_ON = 1'b1;
`else
    localparam bit SCROLL_ON = 1'b0;
`endif

    logic clk, rst_n;
    logic cmd_valid_i, cmd_ready_o, busy_o, done_o, cmd_err_o;
    logic [1:0] cmd_op_i;
    logic [7:0] cmd_char_i, cmd_color_i;
    logic bus_req_i, bus_we_i, bus_sel_i, bus_gnt_o, bus_rvalid_o;
    logic [AW-1:0] bus_addr_i;
    logic [7:0] bus_wdata_i, bus_rdata_o;
    logic [AW-1:0] ch_map_addr_o, col_map_addr_o;
    logic ch_map_wen_o, col_map_wen_o;
    logic [7:0] ch_map_data_o, col_map_data_o, ch_map_data_i, col_map_data_i;

    vga_textmap_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_char_i(cmd_char_i), .cmd_color_i(cmd_color_i),
        .busy_o(busy_o), .done_o(done_o), .cmd_err_o(cmd_err_o),
        .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_sel_i(bus_sel_i),
        .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i),
        .bus_gnt_o(bus_gnt_o), .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o),
        .ch_map_addr_o(ch_map_addr_o), .col_map_addr_o(col_map_addr_o),
        .ch_map_wen_o(ch_map_wen_o), .col_map_wen_o(col_map_wen_o),
        .ch_map_data_o(ch_map_data_o), .col_map_data_o(col_map_data_o),
        .ch_map_data_i(ch_map_data_i), .col_map_data_i(col_map_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Character and colour maps with registered port-A read.
    logic [7:0] mem_ch [N];
    logic [7:0] mem_col[N];
    logic preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < N; k++) begin
                mem_ch[k]  <= 8'(k);
                mem_col[k] <= 8'(k);
            end
        end else begin
            if (ch_map_wen_o)  mem_ch[ch_map_addr_o]   <= ch_map_data_o;
            if (col_map_wen_o) mem_col[col_map_addr_o] <= col_map_data_o;
        end
        ch_map_data_i  <= mem_ch[ch_map_addr_o];
        col_map_data_i <= mem_col[col_map_addr_o];
    end

    // Operation model: a command expands into a list of engine operations, one per free slot.
    typedef struct { int kind; int a; } op_t;   // kind 0 fill-write, 1 read a+COLS, 2 copy-write
    op_t ops[$];
    logic [7:0] ref_ch [N];
    logic [7:0] ref_col[N];
    int ph;               // 0 idle, 1 running, 2 done cycle
    bit pg, rp;
    logic [7:0] rv, fch, fcol, cpy_ch, cpy_col;
    int lch, lcol, wait_cnt;
    int total, bad;
    logic seen_done, seen_gnt, seen_err, seen_rvalid, seen_ready;
    logic [7:0] seen_rdata;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic eval();
        bit g, err_e, e_chw, e_colw;
        int e_cha, e_cola;
        logic [7:0] e_chd, e_cold;
        op_t o;
        seen_done = done_o; seen_gnt = bus_gnt_o; seen_err = cmd_err_o;
        seen_rvalid = bus_rvalid_o; seen_rdata = bus_rdata_o; seen_ready = cmd_ready_o;
        if (!rst_n) begin
            chk("rst_ready", int'(cmd_ready_o), 1);
            chk("rst_busy", int'(busy_o), 0);
            chk("rst_done", int'(done_o), 0);
            chk("rst_err", int'(cmd_err_o), 0);
            chk("rst_gnt", int'(bus_gnt_o), 0);
            chk("rst_rvalid", int'(bus_rvalid_o), 0);
            chk("rst_rdata", int'(bus_rdata_o), 0);
            chk("rst_wen", int'({ch_map_wen_o, col_map_wen_o}), 0);
            chk("rst_addr", int'(ch_map_addr_o) + int'(col_map_addr_o), 0);
            chk("rst_data", int'(ch_map_data_o) + int'(col_map_data_o), 0);
            ph = 0; ops.delete(); pg = 0; rp = 0; lch = 0; lcol = 0; wait_cnt = 0;
            return;
        end
        err_e = (ph == 0) && cmd_valid_i && (cmd_op_i[1] || (cmd_op_i == 2'b01 && !SCROLL_ON));
        if (ph == 0)      g = bus_req_i;
        else if (ph == 1) g = bus_req_i && !pg && (ops[0].kind != 2);
        else              g = 1'b0;
        chk("ready", int'(cmd_ready_o), int'(ph == 0));
        chk("busy", int'(busy_o), int'(ph == 1));
        chk("done", int'(done_o), int'(ph == 2));
        chk("cmd_err", int'(cmd_err_o), int'(err_e));
        chk("bus_gnt", int'(bus_gnt_o), int'(g));
        e_chw = 0; e_colw = 0; e_cha = lch; e_cola = lcol; e_chd = 0; e_cold = 0;
        if (g) begin
            if (bus_sel_i) begin e_cola = int'(bus_addr_i); e_colw = bus_we_i; e_cold = bus_wdata_i; end
            else begin e_cha = int'(bus_addr_i); e_chw = bus_we_i; e_chd = bus_wdata_i; end
        end else if (ph == 1) begin
            o = ops[0];
            if (o.kind == 1) begin
                e_cha = o.a + COLS; e_cola = o.a + COLS;
            end else begin
                e_chw = 1; e_colw = 1; e_cha = o.a; e_cola = o.a;
                e_chd = (o.kind == 0) ? fch : cpy_ch;
                e_cold = (o.kind == 0) ? fcol : cpy_col;
            end
        end
        chk("ch_wen", int'(ch_map_wen_o), int'(e_chw));
        chk("col_wen", int'(col_map_wen_o), int'(e_colw));
        chk("ch_addr", int'(ch_map_addr_o), e_cha);
        chk("col_addr", int'(col_map_addr_o), e_cola);
        if (e_chw) chk("ch_wdata", int'(ch_map_data_o), int'(e_chd));
        if (e_colw) chk("col_wdata", int'(col_map_data_o), int'(e_cold));
        chk("rvalid", int'(bus_rvalid_o), int'(rp));
        if (rp) chk("rdata", int'(bus_rdata_o), int'(rv));
        if (bus_gnt_o) begin
            chk("bus_wait_le2", int'(wait_cnt <= 2), 1);
            wait_cnt = 0;
        end else if (bus_req_i) wait_cnt++;
        else wait_cnt = 0;
        // advance model across the coming clock edge
        rp = g && !bus_we_i;
        if (rp) rv = bus_sel_i ? ref_col[bus_addr_i] : ref_ch[bus_addr_i];
        if (g && bus_we_i) begin
            if (bus_sel_i) ref_col[bus_addr_i] = bus_wdata_i;
            else ref_ch[bus_addr_i] = bus_wdata_i;
        end
        lch = e_cha; lcol = e_cola;
        if (ph == 0) begin
            if (cmd_valid_i && !err_e) begin
                fch = cmd_char_i; fcol = cmd_color_i;
                if (cmd_op_i == 2'b00) begin
                    for (int k = 0; k < N; k++) ops.push_back('{0, k});
                end else begin
                    for (int k = 0; k < N - COLS; k++) begin
                        ops.push_back('{1, k});
                        ops.push_back('{2, k});
                    end
                    for (int k = N - COLS; k < N; k++) ops.push_back('{0, k});
                end
                ph = 1;
            end
        end else if (ph == 1) begin
            if (!g) begin
                o = ops.pop_front();
                if (o.kind == 0) begin ref_ch[o.a] = fch; ref_col[o.a] = fcol; end
                else if (o.kind == 1) begin cpy_ch = ref_ch[o.a + COLS]; cpy_col = ref_col[o.a + COLS]; end
                else begin ref_ch[o.a] = cpy_ch; ref_col[o.a] = cpy_col; end
                if (ops.size() == 0) ph = 2;
            end
        end else begin
            ph = 0;
        end
        pg = g;
    endtask

    task automatic step();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cyc);
        bus_req_i = 0; cmd_valid_i = 0; rst_n = 0;
        repeat (cyc) step();
        rst_n = 1;
    endtask

    task automatic set_preload();
        bus_req_i = 0; cmd_valid_i = 0; preload = 1;
        step();
        preload = 0;
        for (int k = 0; k < N; k++) begin ref_ch[k] = 8'(k); ref_col[k] = 8'(k); end
    endtask

    task automatic bus_rand(input int pct, input bit allow_we);
        if (!bus_req_i || seen_gnt) begin
            bus_req_i   = ($urandom_range(0, 99) < pct);
            bus_addr_i  = AW'($urandom_range(0, N - 1));
            bus_sel_i   = 1'($urandom_range(0, 1));
            bus_we_i    = allow_we ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_wdata_i = 8'($urandom);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] c, input logic [7:0] k,
                          input int pct, input bit we, output int n, output int grants);
        cmd_valid_i = 1; cmd_op_i = op; cmd_char_i = c; cmd_color_i = k;
        bus_rand(pct, we);
        step();
        cmd_valid_i = 0; cmd_op_i = 2'($urandom);
        n = 0; grants = 0;
        do begin
            bus_rand(pct, we);
            step();
            n++;
            if (seen_gnt) grants++;
        end while (!seen_done && n < 12000);
        chk("op_reached_done", int'(seen_done), 1);
        bus_req_i = 0;
    endtask

    task automatic cmp_mem(input string nm);
        int errs = 0;
        for (int k = 0; k < N; k++)
            if (mem_ch[k] !== ref_ch[k] || mem_col[k] !== ref_col[k]) errs++;
        chk(nm, errs, 0);
    endtask

    task automatic scroll_literal(input string nm);
        int errs = 0;
        for (int k = 0; k < N; k++) begin
            if (k < N - COLS) begin
                if (mem_ch[k] !== 8'(k + 80) || mem_col[k] !== 8'(k + 80)) errs++;
            end else if (mem_ch[k] !== 8'h41 || mem_col[k] !== 8'h07) errs++;
        end
        chk(nm, errs, 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n, g, errs;
        bit any_done;
        total = 0; bad = 0; preload = 0; rst_n = 0;
        cmd_valid_i = 0; cmd_op_i = 0; cmd_char_i = 0; cmd_color_i = 0;
        bus_req_i = 0; bus_we_i = 0; bus_sel_i = 0; bus_addr_i = 0; bus_wdata_i = 0;
        ph = 0; pg = 0; rp = 0; rv = 0; fch = 0; fcol = 0; cpy_ch = 0; cpy_col = 0;
        lch = 0; lcol = 0; wait_cnt = 0; seen_gnt = 0; seen_done = 0;
        do_reset(3);
        set_preload();

        // Reserved opcodes and idle bus traffic.
        cmd_valid_i = 1; cmd_op_i = 2'b11; step();
        cmd_valid_i = 0; chk("op11_err_pulse", int'(seen_err), 1);
        step();
        chk("op11_err_single", int'(seen_err), 0);
        chk("op11_ready_kept", int'(seen_ready), 1);
        if (!SCROLL_ON) begin
            cmd_valid_i = 1; cmd_op_i = 2'b01; step();
            cmd_valid_i = 0; chk("op01_rejected", int'(seen_err), 1);
        end
        for (int i = 0; i < 6; i++) begin
            cmd_valid_i = 1; cmd_op_i = 2'b10 + 2'(i % 2); bus_rand(50, 1);
            step();
            cmd_valid_i = 0; step();
        end
        repeat (300) begin bus_rand(60, 1); step(); end
        bus_req_i = 0; step();
        cmp_mem("mem_after_idle_bus");

        // Uncontended CLR.
        run_op(2'b00, 8'h20, 8'h0F, 0, 0, n, g);
        chk("clr_done_cycle", n, 2401);
        errs = 0;
        for (int k = 0; k < N; k++) if (mem_ch[k] !== 8'h20 || mem_col[k] !== 8'h0F) errs++;
        chk("clr_contents", errs, 0);
        step();
        chk("clr_ready_back", int'(seen_ready), 1);

        // CLR with random bus reads and writes.
        run_op(2'b00, 8'($urandom), 8'($urandom), 40, 1, n, g);
        chk("clr_latency_contended", n, 2401 + g);
        cmp_mem("mem_after_clr_contended");

        // Bus read of colour cell 5 during CLR, then reset mid-operation.
        set_preload();
        cmd_valid_i = 1; cmd_op_i = 2'b00; cmd_char_i = 8'h55; cmd_color_i = 8'h66;
        step();
        cmd_valid_i = 0; step(); step();
        bus_req_i = 1; bus_sel_i = 1; bus_we_i = 0; bus_addr_i = AW'(5);
        step();
        chk("rd5_gnt_early", int'(seen_gnt), 1);
        bus_req_i = 0; step();
        chk("rd5_rvalid_early", int'(seen_rvalid), 1);
        chk("rd5_old_value", int'(seen_rdata), 5);
        repeat (20) step();
        bus_req_i = 1; step();
        bus_req_i = 0; step();
        chk("rd5_rvalid_late", int'(seen_rvalid), 1);
        chk("rd5_fill_value", int'(seen_rdata), 8'h66);
        repeat (60) step();
        do_reset(2);
        any_done = 0;
        repeat (40) begin step(); if (seen_done) any_done = 1; end
        chk("no_done_after_reset", int'(any_done), 0);
        cmp_mem("mem_after_reset_abort");

`ifdef VGA_TEXTMAP_SCROLL_EN
        set_preload();
        run_op(2'b01, 8'h41, 8'h07, 0, 0, n, g);
        chk("scroll_done_cycle", n, 4721);
        scroll_literal("scroll_contents");
        cmp_mem("mem_after_scroll");

        set_preload();
        run_op(2'b01, 8'h41, 8'h07, 100, 0, n, g);
        chk("scroll_contended_grants", g, 2399);
        chk("scroll_contended_latency", n, 4721 + g);
        scroll_literal("scroll_contended_contents");
`endif

        // Random command with random traffic.
        run_op(SCROLL_ON ? 2'($urandom_range(0, 1)) : 2'b00, 8'($urandom), 8'($urandom), 30, 1, n, g);
        chk("random_op_latency", n, ((SCROLL_ON && ops.size() == 0 && n > 4000) ? 4721 : 2401) + g);
        repeat (200) begin bus_rand(50, 1); step(); end
        bus_req_i = 0; step();
        cmp_mem("mem_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
